// File: rtl/fir_filter_pipe_pkg.sv
// Shared constants for the pipelined FIR: default widths, pipeline latency
// and the accumulator-width helper.
package fir_filter_pipe_pkg;

    localparam int FIR_DW    = 12;
    localparam int FIR_CW    = 12;
    localparam int FIR_TAPS  = 5;
    localparam int FIR_OUT_W = 22;
    localparam int FIR_LAT   = 4;

    // Wide enough that a TAPS-term sum of full-precision products never overflows.
    function automatic int fir_acc_w(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline register with load enable and async active-low
// reset to zero; used for every data stage of the FIR.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fir_filter_pipe.sv
// Pipelined direct-form FIR with runtime coefficient bank and valid pipe.
// Define FIR_SAT_EN to clamp the output window instead of wrapping.
module fir_filter_pipe
    import fir_filter_pipe_pkg::*;
#(
    parameter int DW        = FIR_DW,
    parameter int CW        = FIR_CW,
    parameter int TAPS      = FIR_TAPS,
    parameter int OUT_W     = FIR_OUT_W,
    parameter int OUT_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic [DW-1:0]           in,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_wdata,
    output logic [OUT_W-1:0]        out,
    output logic                    out_valid,
    output logic                    primed,
    output logic                    sat_flag
);

    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DW + CW;
    localparam int ACC_W = fir_acc_w(DW, CW, TAPS);
    localparam int CNT_W = $clog2(TAPS + 1);

    logic signed [DW-1:0]    x_d   [TAPS];
    logic signed [DW-1:0]    x_q   [TAPS];
    logic signed [CW-1:0]    c_q   [TAPS];
    logic signed [PW-1:0]    p_d   [TAPS];
    logic signed [PW-1:0]    p_q   [TAPS];
    logic signed [ACC_W-1:0] p_ext [TAPS];
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic [FIR_LAT-1:0]      vld_d, vld_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic [OUT_W-1:0]        out_d, out_q;
    logic                    x_en;
    logic                    load_out;
    logic                    unused_acc;

    // Delay line moves only on accepted samples; clr zeroes it in the same edge.
    assign x_en = clr | in_valid;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < TAPS; i++) x_d[i] = '0;
        if (!clr) begin
            x_d[0] = in;
            for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
        end
    end

    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        logic c_we;
        assign c_we = coef_we && (coef_addr == AW'(i));

        pipe_reg #(.W(DW)) u_x (.clk(clk), .rstn(rstn), .en(x_en), .d(x_d[i]), .q(x_q[i]));

        // NOTE: the coefficient bank is reset too, so a fresh filter is all-zero until loaded.
        pipe_reg #(.W(CW)) u_c (.clk(clk), .rstn(rstn), .en(c_we), .d(coef_wdata), .q(c_q[i]));

        assign p_d[i] = PW'(x_q[i]) * PW'(c_q[i]);
        pipe_reg #(.W(PW)) u_p (.clk(clk), .rstn(rstn), .en(1'b1), .d(p_d[i]), .q(p_q[i]));

        assign p_ext[i] = {{(ACC_W-PW){p_q[i][PW-1]}}, p_q[i]};
    end

    always_comb begin
        acc_d = '0;
        for (int i = 0; i < TAPS; i++) acc_d = acc_d + p_ext[i];
    end

    pipe_reg #(.W(ACC_W)) u_acc (.clk(clk), .rstn(rstn), .en(1'b1), .d(acc_d), .q(acc_q));

    always_comb begin
        vld_d = clr ? '0 : {vld_q[FIR_LAT-2:0], in_valid};
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (vld_d[FIR_LAT-1] && (cnt_q != CNT_W'(TAPS))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign load_out   = vld_d[FIR_LAT-1];
    assign unused_acc = ^acc_q;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] WIN_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] WIN_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] win_full;
    logic                    sat_d, sat_q;

    // Arithmetic shift gives floor truncation before the range test.
    assign win_full = acc_q >>> OUT_SHIFT;

    always_comb begin
        out_d = win_full[OUT_W-1:0];
        sat_d = 1'b0;
        if (win_full > WIN_MAX) begin
            out_d = WIN_MAX[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (win_full < WIN_MIN) begin
            out_d = WIN_MIN[OUT_W-1:0];
            sat_d = 1'b1;
        end
    end

    pipe_reg #(.W(1)) u_sat (.clk(clk), .rstn(rstn), .en(load_out), .d(sat_d), .q(sat_q));
    assign sat_flag = sat_q;
`else
    assign out_d    = acc_q[OUT_SHIFT +: OUT_W];
    assign sat_flag = 1'b0;
`endif

    pipe_reg #(.W(OUT_W)) u_out (.clk(clk), .rstn(rstn), .en(load_out), .d(out_d), .q(out_q));

    assign out       = out_q;
    assign out_valid = vld_q[FIR_LAT-1];
    assign primed    = (cnt_q == CNT_W'(TAPS));

endmodule

// File: tb/tb_fir_filter_pipe.sv
// Self-checking bench for fir_filter_pipe: directed scenarios plus random
// traffic, all scored against a sample-level convolution model.
module tb_fir_filter_pipe;

    localparam int DW        = 12;
    localparam int CW        = 12;
    localparam int TAPS      = 5;
    localparam int OUT_W     = 22;
    localparam int OUT_SHIFT = 0;
    localparam int AW        = $clog2(TAPS);

    logic             clk = 1'b0;
    logic             rstn;
    logic             clr;
    logic             in_valid;
    logic [DW-1:0]    in;
    logic             coef_we;
    logic [AW-1:0]    coef_addr;
    logic [CW-1:0]    coef_wdata;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             primed;
    logic             sat_flag;

    int checks   = 0;
    int failures = 0;

    fir_filter_pipe #(
        .DW(DW), .CW(CW), .TAPS(TAPS), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in(in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .out(out), .out_valid(out_valid), .primed(primed), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Reference model: history of accepted samples and scheduled outputs.
    typedef struct {
        int               due;
        logic [OUT_W-1:0] val;
        bit               sat;
    } exp_t;

    int               cyc = 0;
    int               coef_m [TAPS];
    int               hist   [TAPS];
    exp_t             pend   [$];
    int               n_out;
    logic [OUT_W-1:0] last_out;
    bit               last_sat;
    bit               exp_valid;
    bit               exp_primed;

    task automatic reset_model();
        for (int i = 0; i < TAPS; i++) begin
            coef_m[i] = 0;
            hist[i]   = 0;
        end
        pend.delete();
        n_out      = 0;
        last_out   = '0;
        last_sat   = 1'b0;
        exp_valid  = 1'b0;
        exp_primed = 1'b0;
    endtask

    // One clock edge; the model consumes the inputs that were present at it.
    task automatic step();
        exp_t   e;
        longint s, w, hi, lo;
        @(posedge clk);
        #1;
        cyc++;
        if (coef_we && int'(coef_addr) < TAPS) coef_m[coef_addr] = $signed(coef_wdata);
        if (clr) begin
            for (int i = 0; i < TAPS; i++) hist[i] = 0;
            pend.delete();
            n_out = 0;
        end else if (in_valid) begin
            for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = $signed(in);
            s = 0;
            for (int i = 0; i < TAPS; i++) s += longint'(hist[i]) * longint'(coef_m[i]);
            w  = s >>> OUT_SHIFT;
            hi = (longint'(1) <<< (OUT_W - 1)) - 1;
            lo = -hi - 1;
            e.due = cyc + 3;
            e.val = w[OUT_W-1:0];
            e.sat = 1'b0;
`ifdef FIR_SAT_EN
            if (w > hi) begin
                e.val = hi[OUT_W-1:0];
                e.sat = 1'b1;
            end else if (w < lo) begin
                e.val = lo[OUT_W-1:0];
                e.sat = 1'b1;
            end
`endif
            pend.push_back(e);
        end
        exp_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e         = pend.pop_front();
            exp_valid = 1'b1;
            last_out  = e.val;
            last_sat  = e.sat;
            if (n_out < TAPS) n_out++;
        end
        exp_primed = (n_out == TAPS);
    endtask

    task automatic load_coefs(input int c [TAPS]);
        for (int i = 0; i < TAPS; i++) begin
            coef_we    = 1'b1;
            coef_addr  = AW'(i);
            coef_wdata = CW'(c[i]);
            step();
        end
        coef_we = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, primed, sat_flag} !== 3'b000 || out !== '0) begin
            failures++;
            $display("FAIL reset: got v=%b pr=%b sat=%b out=%0d, want all 0", out_valid, primed, sat_flag, out);
        end
        rstn = 1'b1;
        reset_model();
    endtask

    // Single unit sample followed by zeros; expects history-free start.
    task automatic test_impulse(input string tag, input int want [TAPS]);
        int got [$];
        int acc_cyc, first_cyc, primed_idx, g;
        acc_cyc = 0; first_cyc = -1; primed_idx = -1;
        for (int t = 0; t < TAPS + 6; t++) begin
            in_valid = (t < TAPS);
            in       = (t == 0) ? DW'(1) : '0;
            step();
            if (t == 0) acc_cyc = cyc;
            checks++;
            if ({out_valid, out, sat_flag, primed} !== {exp_valid, last_out, last_sat, exp_primed}) begin
                failures++;
                $display("FAIL %s cyc=%0d: got v=%b out=%0d sat=%b pr=%b, want v=%b out=%0d sat=%b pr=%b", tag, cyc,
                         out_valid, $signed(out), sat_flag, primed, exp_valid, $signed(last_out), last_sat, exp_primed);
            end
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                got.push_back(int'($signed(out)));
            end
            if (primed && primed_idx < 0) primed_idx = got.size();
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != TAPS) begin
            failures++;
            $display("FAIL %s_count: got %0d pulses, want %0d", tag, got.size(), TAPS);
        end
        for (int i = 0; i < TAPS; i++) begin
            g = (i < got.size()) ? got[i] : -99999;
            checks++;
            if (g != want[i]) begin
                failures++;
                $display("FAIL %s_val[%0d]: got %0d, want %0d", tag, i, g, want[i]);
            end
        end
        checks++;
        if (first_cyc != acc_cyc + 3) begin
            failures++;
            $display("FAIL %s_latency: got %0d edges, want 3", tag, first_cyc - acc_cyc);
        end
        checks++;
        if (primed_idx != TAPS) begin
            failures++;
            $display("FAIL %s_primed: rose at pulse %0d, want %0d", tag, primed_idx, TAPS);
        end
    endtask

    task automatic test_overflow();
        logic [OUT_W-1:0] want_out;
        bit               want_sat;
        load_coefs('{default: 2047});
        flush();
        for (int t = 0; t < 14; t++) begin
            in_valid = (t < 10);
            in       = DW'(2047);
            step();
            checks++;
            if ({out_valid, out, sat_flag, primed} !== {exp_valid, last_out, last_sat, exp_primed}) begin
                failures++;
                $display("FAIL overflow cyc=%0d: got v=%b out=%0d sat=%b pr=%b, want v=%b out=%0d sat=%b pr=%b", cyc,
                         out_valid, $signed(out), sat_flag, primed, exp_valid, $signed(last_out), last_sat, exp_primed);
            end
        end
        in_valid = 1'b0;
`ifdef FIR_SAT_EN
        want_out = OUT_W'(2097151);
        want_sat = 1'b1;
`else
        want_out = OUT_W'(-20475);
        want_sat = 1'b0;
`endif
        checks++;
        if (out !== want_out || sat_flag !== want_sat) begin
            failures++;
            $display("FAIL overflow_steady: got out=%0d sat=%b, want out=%0d sat=%b",
                     $signed(out), sat_flag, $signed(want_out), want_sat);
        end
    endtask

    task automatic test_gapped();
        int pat_v [10] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        int pat_d [10] = '{10, 0, 20, 0, 30, 0, 0, 0, 0, 0};
        int want  [3]  = '{10, 30, 60};
        int got [$];
        int g;
        load_coefs('{default: 1});
        flush();
        for (int t = 0; t < 10; t++) begin
            in_valid = (pat_v[t] != 0);
            in       = DW'(pat_d[t]);
            step();
            checks++;
            if ({out_valid, out, sat_flag, primed} !== {exp_valid, last_out, last_sat, exp_primed}) begin
                failures++;
                $display("FAIL gapped cyc=%0d: got v=%b out=%0d sat=%b pr=%b, want v=%b out=%0d sat=%b pr=%b", cyc,
                         out_valid, $signed(out), sat_flag, primed, exp_valid, $signed(last_out), last_sat, exp_primed);
            end
            if (out_valid) got.push_back(int'($signed(out)));
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL gapped_count: got %0d pulses, want 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            g = (i < got.size()) ? got[i] : -99999;
            checks++;
            if (g != want[i]) begin
                failures++;
                $display("FAIL gapped_val[%0d]: got %0d, want %0d", i, g, want[i]);
            end
        end
    endtask

    task automatic test_clr();
        load_coefs('{1, 2, 3, 4, 9});
        flush();
        for (int t = 0; t < 7; t++) begin
            in_valid = 1'b1;
            in       = DW'($urandom);
            step();
            checks++;
            if ({out_valid, out, sat_flag, primed} !== {exp_valid, last_out, last_sat, exp_primed}) begin
                failures++;
                $display("FAIL clr_pre cyc=%0d: got v=%b out=%0d sat=%b pr=%b, want v=%b out=%0d sat=%b pr=%b", cyc,
                         out_valid, $signed(out), sat_flag, primed, exp_valid, $signed(last_out), last_sat, exp_primed);
            end
        end
        // clr coincides with a sample and a coefficient write
        clr = 1'b1; in_valid = 1'b1; in = DW'(777);
        coef_we = 1'b1; coef_addr = AW'(4); coef_wdata = CW'(5);
        step();
        clr = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
        checks++;
        if (primed !== 1'b0 || out_valid !== 1'b0 || out !== last_out) begin
            failures++;
            $display("FAIL clr_edge: got pr=%b v=%b out=%0d, want pr=0 v=0 out=%0d",
                     primed, out_valid, $signed(out), $signed(last_out));
        end
        for (int t = 0; t < 5; t++) begin
            step();
            checks++;
            if ({out_valid, out, primed} !== {1'b0, last_out, 1'b0}) begin
                failures++;
                $display("FAIL clr_drain cyc=%0d: got v=%b out=%0d pr=%b, want v=0 out=%0d pr=0",
                         cyc, out_valid, $signed(out), primed, $signed(last_out));
            end
        end
        test_impulse("clr_impulse", '{1, 2, 3, 4, 5});
    endtask

    task automatic test_coef();
        coef_we = 1'b1; coef_addr = AW'(7); coef_wdata = CW'(99);
        step();
        coef_addr = AW'(2); coef_wdata = CW'(-3);
        step();
        coef_we = 1'b0;
        flush();
        test_impulse("coef_impulse", '{1, 2, -3, 4, 5});
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in         = DW'($urandom);
            coef_we    = ($urandom_range(0, 19) == 0);
            coef_addr  = AW'($urandom_range(0, 7));
            coef_wdata = CW'($urandom);
            clr        = ($urandom_range(0, 49) == 0);
            step();
            checks++;
            if ({out_valid, out, sat_flag, primed} !== {exp_valid, last_out, last_sat, exp_primed}) begin
                failures++;
                $display("FAIL random cyc=%0d: got v=%b out=%0d sat=%b pr=%b, want v=%b out=%0d sat=%b pr=%b", cyc,
                         out_valid, $signed(out), sat_flag, primed, exp_valid, $signed(last_out), last_sat, exp_primed);
            end
        end
        in_valid = 1'b0; coef_we = 1'b0; clr = 1'b0;
    endtask

    task automatic test_async_reset();
        load_coefs('{default: 3});
        flush();
        for (int t = 0; t < 8; t++) begin
            in_valid = 1'b1;
            in       = DW'(100);
            step();
            checks++;
            if ({out_valid, out, sat_flag, primed} !== {exp_valid, last_out, last_sat, exp_primed}) begin
                failures++;
                $display("FAIL arst_pre cyc=%0d: got v=%b out=%0d sat=%b pr=%b, want v=%b out=%0d sat=%b pr=%b", cyc,
                         out_valid, $signed(out), sat_flag, primed, exp_valid, $signed(last_out), last_sat, exp_primed);
            end
        end
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if ({out_valid, primed, sat_flag} !== 3'b000 || out !== '0) begin
            failures++;
            $display("FAIL arst_between_edges: got v=%b pr=%b sat=%b out=%0d, want all 0",
                     out_valid, primed, sat_flag, $signed(out));
        end
        @(posedge clk);
        #3;
        rstn     = 1'b1;
        in_valid = 1'b0;
        reset_model();
        test_impulse("rst_impulse", '{default: 0});
    endtask

    initial begin
        test_reset();
        load_coefs('{1, 2, 3, 4, 5});
        test_impulse("impulse", '{1, 2, 3, 4, 5});
        test_overflow();
        test_gapped();
        test_clr();
        test_coef();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
